// File: rtl/mem_bus_initiator.sv
// -----------------------------------------------------------------------------
// mem_bus_initiator
//
// Turns a command handshake into a single-outstanding request to a memory
// controller, then returns the completion through a response handshake.
// The sequence is IDLE -> ISSUE -> RESP. RESP always lasts at least one cycle,
// so the request strobes go low between consecutive transactions.
//
// Optional build macro MEM_BUS_INITIATOR_TIMEOUT_EN adds a watchdog. The
// watchdog aborts an ISSUE phase after TIMEOUT_CYCLES cycles without ack.
// The aborted transaction returns rsp_err=1 and rsp_rdata=0.
// Without the macro, ISSUE waits for ack indefinitely and rsp_err is tied to 0.
//
// Ports
//   hwclk, nrst             clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready only in IDLE)
//   cmd_write, cmd_dbl      write(1)/read(0), 16-bit(1)/8-bit(0)
//   cmd_addr, cmd_wdata     command address and write data
//   rsp_valid/rsp_ready     response handshake (rsp_valid only in RESP)
//   rsp_rdata, rsp_err      read data (0 for writes), timeout flag
//   mem_read_en, mem_write_en, dbl_byte_en, address, data_in
//                           request to controller, driven only in ISSUE
//   ack, data_output        completion strobe and read data from controller
// -----------------------------------------------------------------------------
module mem_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        hwclk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_dbl,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic        dbl_byte_en,
  output logic [15:0] address,
  output logic [15:0] data_in,
  input  logic        ack,
  input  logic [15:0] data_output
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state, state_nxt;
  logic        wr_p0, dbl_p0;
  logic [15:0] addr_p0, wdata_p0;
  logic        accept, issue, done_ok, tmo_hit;

  assign accept  = (state == IDLE) && cmd_valid;
  assign issue   = (state == ISSUE);
  assign done_ok = issue && ack;

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        rsp_err_q;

  // Ack in the expiry cycle takes priority, so expiry requires ack low.
  assign tmo_hit = issue && !ack && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept)
        tmo_cnt <= '0;
      else if (issue && !ack && !tmo_hit)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (done_ok)
        rsp_err_q <= 1'b0;
      else if (tmo_hit)
        rsp_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)          state_nxt = ISSUE;
      ISSUE:   if (ack || tmo_hit)     state_nxt = RESP;
      RESP:    if (rsp_ready)          state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Command latch and response capture
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      wr_p0     <= 1'b0;
      dbl_p0    <= 1'b0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wr_p0    <= cmd_write;
        dbl_p0   <= cmd_dbl;
        addr_p0  <= cmd_addr;
        wdata_p0 <= cmd_wdata;
      end
      if (done_ok) begin
        if (wr_p0)       rsp_rdata <= '0;
        else if (dbl_p0) rsp_rdata <= data_output;
        else             rsp_rdata <= {8'h00, data_output[7:0]};
      end else if (tmo_hit) begin
        rsp_rdata <= '0;
      end
    end
  end

  // Request and handshake outputs decode directly from state, so they clear
  // immediately on reset and never depend combinationally on cmd_valid/rsp_ready.
  assign cmd_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign mem_read_en  = issue && !wr_p0;
  assign mem_write_en = issue && wr_p0;
  assign dbl_byte_en  = issue && dbl_p0;
  assign address      = issue ? addr_p0 : 16'h0000;
  assign data_in      = (issue && wr_p0) ? wdata_p0 : 16'h0000;

endmodule

// File: tb/tb_mem_bus_initiator.sv
module tb_mem_bus_initiator;

  logic        hwclk = 1'b0;
  logic        nrst;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_dbl;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mem_read_en, mem_write_en, dbl_byte_en;
  logic [15:0] address, data_in;
  logic        ack;
  logic [15:0] data_output;

  int total = 0;
  int bad   = 0;

  always #5 hwclk = ~hwclk;

  mem_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .hwclk(hwclk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_dbl(cmd_dbl),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .dbl_byte_en(dbl_byte_en), .address(address), .data_in(data_in),
    .ack(ack), .data_output(data_output)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  // Strobe bundle {rd, wr, dbl} for compact checks.
  function automatic logic [31:0] strb();
    return {29'd0, mem_read_en, mem_write_en, dbl_byte_en};
  endfunction

  task automatic send(input logic wr, input logic dbl, input logic [15:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_dbl = dbl; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0; cmd_addr = 16'h0000; cmd_wdata = 16'h0000;
  endtask

  initial begin
    nrst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_dbl = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0; ack = 1'b0; data_output = '0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_strobes", strb(), 0);
    chk("rst_addr", address, 0);
    chk("rst_data_in", data_in, 0);
    #9 nrst = 1'b1;
    step();

    // 8-bit read, ack on the third ISSUE cycle
    send(1'b0, 1'b0, 16'hFF85, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      chk("r8_strobes", strb(), 32'b100);
      chk("r8_addr", address, 16'hFF85);
      chk("r8_data_in", data_in, 0);
      chk("r8_cmd_ready", cmd_ready, 0);
      chk("r8_rsp_valid", rsp_valid, 0);
      if (i == 2) begin ack = 1'b1; data_output = 16'h12AB; end
      step();
    end
    ack = 1'b0; data_output = 16'h0000;
    chk("r8_rsp_valid", rsp_valid, 1);
    chk("r8_rdata", rsp_rdata, 16'h00AB);
    chk("r8_err", rsp_err, 0);
    chk("r8_strobes_off", strb(), 0);
    chk("r8_addr_off", address, 0);
    // spurious ack in RESP
    ack = 1'b1; data_output = 16'hFFFF;
    step();
    ack = 1'b0;
    chk("sp_resp_valid", rsp_valid, 1);
    chk("sp_resp_rdata", rsp_rdata, 16'h00AB);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("r8_done_ready", cmd_ready, 1);
    chk("r8_done_valid", rsp_valid, 0);
    // spurious ack in IDLE
    ack = 1'b1; data_output = 16'h9999;
    step();
    ack = 1'b0;
    chk("sp_idle_ready", cmd_ready, 1);
    chk("sp_idle_strobes", strb(), 0);
    chk("sp_idle_valid", rsp_valid, 0);
    chk("sp_idle_rdata", rsp_rdata, 16'h00AB);

    // 16-bit write, ack in first ISSUE cycle, rsp_ready high
    rsp_ready = 1'b1;
    send(1'b1, 1'b1, 16'hFFD1, 16'hC350);
    chk("w16_strobes", strb(), 32'b011);
    chk("w16_addr", address, 16'hFFD1);
    chk("w16_data_in", data_in, 16'hC350);
    ack = 1'b1; data_output = 16'h1234;
    step();
    ack = 1'b0;
    chk("w16_rsp_valid", rsp_valid, 1);
    chk("w16_rdata", rsp_rdata, 0);
    chk("w16_err", rsp_err, 0);
    chk("w16_strobes_off", strb(), 0);
    chk("w16_data_in_off", data_in, 0);
    step();
    chk("w16_idle_ready", cmd_ready, 1);
    chk("w16_idle_valid", rsp_valid, 0);

    // Back-to-back 16-bit reads with first response stalled 4 cycles
    rsp_ready = 1'b0;
    send(1'b0, 1'b1, 16'h1000, 16'h0000);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_dbl = 1'b1; cmd_addr = 16'h2000;
    chk("b2b_a_strobes", strb(), 32'b101);
    chk("b2b_a_addr", address, 16'h1000);
    ack = 1'b1; data_output = 16'hBEEF;
    step();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_hold_valid", rsp_valid, 1);
      chk("b2b_hold_rdata", rsp_rdata, 16'hBEEF);
      chk("b2b_hold_ready", cmd_ready, 0);
      chk("b2b_hold_strobes", strb(), 0);
      step();
    end
    rsp_ready = 1'b1;
    chk("b2b_last_valid", rsp_valid, 1);
    step();
    chk("b2b_gap_ready", cmd_ready, 1);
    chk("b2b_gap_strobes", strb(), 0);
    chk("b2b_gap_valid", rsp_valid, 0);
    step();
    cmd_valid = 1'b0;
    chk("b2b_b_strobes", strb(), 32'b101);
    chk("b2b_b_addr", address, 16'h2000);
    ack = 1'b1; data_output = 16'h7F01;
    step();
    ack = 1'b0;
    chk("b2b_b_valid", rsp_valid, 1);
    chk("b2b_b_rdata", rsp_rdata, 16'h7F01);
    step();
    chk("b2b_b_done", cmd_ready, 1);

    // Reset during ISSUE of a write
    send(1'b1, 1'b0, 16'h0300, 16'h00EE);
    chk("rs_wr_strobes", strb(), 32'b010);
    chk("rs_data_in", data_in, 16'h00EE);
    #2 nrst = 1'b0;
    #1;
    chk("rs_strobes_drop", strb(), 0);
    chk("rs_addr_drop", address, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_cmd_ready", cmd_ready, 1);
    #2 nrst = 1'b1;
    step();
    chk("rs_after_valid", rsp_valid, 0);
    chk("rs_after_ready", cmd_ready, 1);
    send(1'b0, 1'b0, 16'h0042, 16'h0000);
    chk("rs_next_strobes", strb(), 32'b100);
    chk("rs_next_addr", address, 16'h0042);
    ack = 1'b1; data_output = 16'hABCD;
    step();
    ack = 1'b0;
    chk("rs_next_valid", rsp_valid, 1);
    chk("rs_next_rdata", rsp_rdata, 16'h00CD);
    step();

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    // Timeout with TIMEOUT_CYCLES=4, no ack
    send(1'b0, 1'b1, 16'h0ABC, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk("to_strobes", strb(), 32'b101);
      step();
    end
    chk("to_strobes_off", strb(), 0);
    chk("to_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    step();
    // Ack on the 4th cycle wins over expiry
    send(1'b0, 1'b1, 16'h0ABD, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk("ta_strobes", strb(), 32'b101);
      if (i == 3) begin ack = 1'b1; data_output = 16'h5A5A; end
      step();
    end
    ack = 1'b0;
    chk("ta_valid", rsp_valid, 1);
    chk("ta_err", rsp_err, 0);
    chk("ta_rdata", rsp_rdata, 16'h5A5A);
    step();
`else
    // No watchdog: ISSUE persists well beyond any timeout
    send(1'b0, 1'b1, 16'h0ABC, 16'h0000);
    for (int i = 0; i < 20; i++) step();
    chk("nt_strobes", strb(), 32'b101);
    chk("nt_valid", rsp_valid, 0);
    ack = 1'b1; data_output = 16'h5A5A;
    step();
    ack = 1'b0;
    chk("nt_valid_end", rsp_valid, 1);
    chk("nt_err", rsp_err, 0);
    chk("nt_rdata", rsp_rdata, 16'h5A5A);
    step();
`endif
    chk("end_idle", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning ISSUE-state cycles without ack before abort (range 1..65535).
REQ-002 SHALL have port hwclk  input  1  clock, rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1  command handshake.
REQ-005 SHALL have ports cmd_write input 1, cmd_dbl input 1  write (1) or read (0); 16-bit (1) or 8-bit (0) access.
REQ-006 SHALL have ports cmd_addr input 16, cmd_wdata input 16  command address and write data.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-008 SHALL have ports rsp_rdata output 16, rsp_err output 1  read data; timeout flag.
REQ-009 SHALL have ports mem_read_en, mem_write_en, dbl_byte_en  output 1 each  request strobes to memory controller.
REQ-010 SHALL have ports address output 16, data_in output 16  request address and write data to controller.
REQ-011 SHALL have ports ack input 1, data_output input 16  completion strobe and read data from controller.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, RESP; exactly one transaction outstanding.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; command accepted on edge with cmd_valid&cmd_ready, latching all cmd_* fields; next state ISSUE.
REQ-014 SHALL in ISSUE drive mem_read_en=~write, mem_write_en=write, dbl_byte_en=dbl, address, data_in from latched values; all held constant until exit.
REQ-015 SHALL drive data_in=0 for reads and mem_read_en/mem_write_en/dbl_byte_en=0 in IDLE and RESP (address/data_in=0 there).
REQ-016 SHALL on ack=1 sampled in ISSUE: capture data_output into rsp_rdata for reads (for 8-bit reads, bits 15:8 forced 0), rsp_rdata=0 for writes, rsp_err=0; next state RESP.
REQ-017 SHALL ignore ack in IDLE and RESP.
REQ-018 SHALL in RESP drive rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_valid&rsp_ready edge; then IDLE.
REQ-019 SHALL guarantee strobes low for at least one cycle between consecutive transactions (RESP minimum one cycle).
REQ-020 SHALL have minimum latency acceptance->rsp_valid of 2 cycles (ack in first ISSUE cycle); command-to-command throughput of 3 cycles when rsp_ready held high.
REQ-021 SHALL not combinationally depend on cmd_valid for cmd_ready nor on rsp_ready for rsp_valid.

Reset
REQ-022 SHALL on nrst low asynchronously enter IDLE; cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all strobes 0, address=0, data_in=0, timeout counter=0.
REQ-023 SHALL abandon any in-flight transaction on reset with no response generated.

Configuration
REQ-024 SHALL compile a timeout watchdog when macro MEM_BUS_INITIATOR_TIMEOUT_EN is defined.
REQ-025 SHALL with macro: 16-bit counter cleared on entry to ISSUE, increments each ISSUE cycle without ack; when count reaches TIMEOUT_CYCLES-1 without ack, transition to RESP with rsp_err=1, rsp_rdata=0, strobes dropped next cycle.
REQ-026 SHALL with macro: ack in the same cycle as timeout expiry wins (normal completion, rsp_err=0).
REQ-027 SHALL without macro: no counter, ISSUE waits for ack indefinitely, rsp_err tied 0.

Verification
REQ-028 8-bit read addr 0xFF85, ack after 3 cycles with data_output=0x12AB -> strobes high 3 cycles stable, rsp_valid with rsp_rdata=0x00AB, rsp_err=0.
REQ-029 16-bit write addr 0xFFD1 data 0xC350, ack in first ISSUE cycle -> mem_write_en=1, dbl_byte_en=1, data_in=0xC350 one cycle; rsp_rdata=0x0000 two cycles after acceptance.
REQ-030 Back-to-back 16-bit reads, rsp_ready low 4 cycles on first -> rsp_valid/rsp_rdata held 4 cycles, cmd_ready=0 throughout, second issue only after first response consumed, strobes low >=1 cycle between.
REQ-031 Macro defined, TIMEOUT_CYCLES=4, ack never asserted -> strobes high exactly 4 cycles, rsp_err=1, rsp_rdata=0; repeat with ack on 4th cycle -> rsp_err=0.
REQ-032 nrst pulsed low during ISSUE of a write -> strobes drop immediately, no rsp_valid, cmd_ready=1 after release; next command completes normally.
REQ-033 Spurious ack pulses in IDLE and RESP -> no state change, rsp_rdata unchanged.
